// File: rtl/moving_average_mc.sv
// Multi-channel boxcar moving average over the last 2^win_pow samples of each channel.
// Per-channel ring/sum/fill state updates in the accept cycle; the result is registered one cycle later.
module moving_average_mc #(
    parameter int DATA_W  = 16,
    parameter int NUM_CH  = 4,
    parameter int MAX_POW = 4,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int POW_W   = $clog2(MAX_POW + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear,
    input  logic [POW_W-1:0]  win_pow,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [CH_W-1:0]   sample_in_ch,
    input  logic              sample_in_valid,
    output logic [DATA_W-1:0] sample_out,
    output logic [CH_W-1:0]   sample_out_ch,
    output logic              sample_out_valid,
    output logic              sample_out_primed
);

    localparam int DEPTH = 1 << MAX_POW;
    localparam int SUM_W = DATA_W + MAX_POW + 1;

    logic [DATA_W-1:0]       ring_q [NUM_CH][DEPTH];
    logic signed [SUM_W-1:0] sum_q  [NUM_CH];
    logic [MAX_POW-1:0]      ptr_q  [NUM_CH];
    logic [MAX_POW:0]        fill_q [NUM_CH];
    logic [POW_W-1:0]        pow_q;

    logic [DATA_W-1:0]       out_q;
    logic [CH_W-1:0]         out_ch_q;
    logic                    out_valid_q;
    logic                    out_primed_q;

    logic [POW_W-1:0]        pow_eff;
    logic                    flush;
    logic                    accept;
    logic [MAX_POW:0]        win_w;
    logic [MAX_POW-1:0]      ptr_base;
    logic [MAX_POW-1:0]      old_idx;
    logic [MAX_POW-1:0]      ptr_d;
    logic [MAX_POW:0]        fill_base;
    logic [MAX_POW:0]        fill_d;
    logic [DATA_W-1:0]       old_val;
    logic signed [SUM_W-1:0] sum_base;
    logic signed [SUM_W-1:0] old_ext;
    logic signed [SUM_W-1:0] in_ext;
    logic signed [SUM_W-1:0] sum_d;
    logic signed [SUM_W-1:0] rnd;
    logic signed [SUM_W-1:0] mean;
    logic [DATA_W-1:0]       out_d;
    logic                    primed_d;

    always_comb begin
        pow_eff   = (win_pow > POW_W'(MAX_POW)) ? POW_W'(MAX_POW) : win_pow;
        flush     = clear || (pow_eff != pow_q);
        accept    = sample_in_valid && (32'(sample_in_ch) < 32'(NUM_CH));
        win_w     = (MAX_POW + 1)'(1) << pow_eff;

        // A flush in this cycle means the accepted sample sees an all-zero channel state.
        ptr_base  = flush ? '0 : ptr_q[sample_in_ch];
        fill_base = flush ? '0 : fill_q[sample_in_ch];
        sum_base  = flush ? '0 : sum_q[sample_in_ch];
        old_idx   = ptr_base - win_w[MAX_POW-1:0];
        old_val   = flush ? '0 : ring_q[sample_in_ch][old_idx];

        old_ext   = {{(SUM_W - DATA_W){old_val[DATA_W-1]}}, old_val};
        in_ext    = {{(SUM_W - DATA_W){sample_in[DATA_W-1]}}, sample_in};
        sum_d     = sum_base - old_ext + in_ext;
        ptr_d     = ptr_base + 1'b1;
        fill_d    = (fill_base == (MAX_POW + 1)'(DEPTH)) ? fill_base : fill_base + 1'b1;
        primed_d  = (fill_d >= win_w);

        rnd       = (pow_eff == '0) ? '0 : SUM_W'(1) << (pow_eff - 1'b1);
        mean      = (sum_d + rnd) >>> pow_eff;
        out_d     = (enable && (pow_eff != '0)) ? mean[DATA_W-1:0] : sample_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                for (int unsigned d = 0; d < DEPTH; d++) begin
                    ring_q[c][d] <= '0;
                end
                sum_q[c]  <= '0;
                ptr_q[c]  <= '0;
                fill_q[c] <= '0;
            end
            pow_q        <= '0;
            out_q        <= '0;
            out_ch_q     <= '0;
            out_valid_q  <= 1'b0;
            out_primed_q <= 1'b0;
        end else begin
            pow_q <= pow_eff;
            if (flush) begin
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    for (int unsigned d = 0; d < DEPTH; d++) begin
                        ring_q[c][d] <= '0;
                    end
                    sum_q[c]  <= '0;
                    ptr_q[c]  <= '0;
                    fill_q[c] <= '0;
                end
            end
            // Later assignments override the flush for the accepted channel.
            if (accept) begin
                ring_q[sample_in_ch][ptr_base] <= sample_in;
                sum_q[sample_in_ch]            <= sum_d;
                ptr_q[sample_in_ch]            <= ptr_d;
                fill_q[sample_in_ch]           <= fill_d;
                out_q                          <= out_d;
                out_ch_q                       <= sample_in_ch;
                out_primed_q                   <= primed_d;
            end
            out_valid_q <= accept;
        end
    end

    assign sample_out        = out_q;
    assign sample_out_ch     = out_ch_q;
    assign sample_out_valid  = out_valid_q;
    assign sample_out_primed = out_primed_q;

endmodule

// File: tb/tb_moving_average_mc.sv
// Randomized and directed bench for moving_average_mc against a queue-based windowed-mean model.
module tb_moving_average_mc;

    localparam int DATA_W  = 16;
    localparam int NUM_CH  = 4;
    localparam int MAX_POW = 4;
    localparam int CH_W    = 2;
    localparam int POW_W   = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b1;
    logic              clear = 1'b0;
    logic [POW_W-1:0]  win_pow = '0;
    logic [DATA_W-1:0] sample_in = '0;
    logic [CH_W-1:0]   sample_in_ch = '0;
    logic              sample_in_valid = 1'b0;
    logic [DATA_W-1:0] sample_out, b_out;
    logic [CH_W-1:0]   sample_out_ch, b_ch;
    logic              sample_out_valid, sample_out_primed, b_valid, b_primed;

    int errors = 0;
    int checks = 0;

    // Reference model: samples received per channel since last flush (newest at back).
    int hist[NUM_CH][$];
    int m_pow = 0;
    logic              exp_valid = 1'b0;
    logic              exp_primed = 1'b0;
    logic [CH_W-1:0]   exp_ch = '0;
    logic [DATA_W-1:0] exp_out = '0;

    moving_average_mc #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .MAX_POW(MAX_POW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .win_pow(win_pow),
        .sample_in(sample_in), .sample_in_ch(sample_in_ch), .sample_in_valid(sample_in_valid),
        .sample_out(sample_out), .sample_out_ch(sample_out_ch),
        .sample_out_valid(sample_out_valid), .sample_out_primed(sample_out_primed)
    );

    // Three-channel instance: channel index 3 is out of range here.
    moving_average_mc #(.DATA_W(DATA_W), .NUM_CH(3), .MAX_POW(MAX_POW)) dut3 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .win_pow(win_pow),
        .sample_in(sample_in), .sample_in_ch(sample_in_ch), .sample_in_valid(sample_in_valid),
        .sample_out(b_out), .sample_out_ch(b_ch),
        .sample_out_valid(b_valid), .sample_out_primed(b_primed)
    );

    always #5 clk = ~clk;

    function automatic int ref_mean(int ch, int w);
        longint s = 0;
        longint q;
        int n = hist[ch].size();
        for (int i = 0; i < w && i < n; i++) s += hist[ch][n-1-i];
        q = s + w / 2;
        if (q >= 0) return int'(q / w);
        return -int'((-q + w - 1) / w);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) hist[c].delete();
        m_pow = 0;
        exp_valid = 1'b0; exp_primed = 1'b0; exp_ch = '0; exp_out = '0;
    endtask

    task automatic step(input bit v, input int ch, input int d, input bit clr, input bit en, input int wp);
        int p;
        int w;
        @(negedge clk);
        sample_in_valid = v;
        sample_in_ch    = ch[CH_W-1:0];
        sample_in       = d[DATA_W-1:0];
        clear           = clr;
        enable          = en;
        win_pow         = wp[POW_W-1:0];
        p = (wp > MAX_POW) ? MAX_POW : wp;
        if (clr || p != m_pow) for (int c = 0; c < NUM_CH; c++) hist[c].delete();
        m_pow = p;
        w = 1 << p;
        exp_valid = v && (ch < NUM_CH);
        if (exp_valid) begin
            hist[ch].push_back(d);
            if (hist[ch].size() > (1 << MAX_POW)) void'(hist[ch].pop_front());
            exp_primed = (hist[ch].size() >= w);
            exp_ch     = ch[CH_W-1:0];
            exp_out    = (en && p > 0) ? 16'(ref_mean(ch, w)) : d[DATA_W-1:0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({sample_out_valid, sample_out_ch, sample_out, sample_out_primed} !== '0) begin
            errors++;
            $display("FAIL reset: got v=%0b ch=%0d out=%0d primed=%0b, want all 0",
                     sample_out_valid, sample_out_ch, sample_out, sample_out_primed);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        int din[5] = '{4, 8, 12, 16, 20};
        int eout[5] = '{1, 3, 6, 10, 14};
        bit ep[5] = '{0, 0, 0, 1, 1};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 0, din[i], i == 0, 1'b1, 2);
            checks++;
            if ({sample_out_valid, sample_out_ch, sample_out, sample_out_primed} !==
                {1'b1, 2'd0, 16'(eout[i]), ep[i]}) begin
                errors++;
                $display("FAIL basic[%0d]: got v=%0b out=%0d primed=%0b, want v=1 out=%0d primed=%0b",
                         i, sample_out_valid, $signed(sample_out), sample_out_primed, eout[i], ep[i]);
            end
        end
        step(1'b0, 0, 0, 1'b0, 1'b1, 2);
        checks++;
        if (sample_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: got valid=%0b, want 0", sample_out_valid);
        end
    endtask

    task automatic test_negative();
        int eout[6] = '{-1, -1, -2, -3, -3, -3};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 0, -3, i == 0, 1'b1, 2);
            checks++;
            if ($signed(sample_out) !== 16'(eout[i]) || sample_out_valid !== 1'b1) begin
                errors++;
                $display("FAIL negative[%0d]: got out=%0d v=%0b, want out=%0d v=1",
                         i, $signed(sample_out), sample_out_valid, eout[i]);
            end
        end
    endtask

    task automatic test_interleave();
        for (int i = 0; i < 40; i++) begin
            int ch = (i % 2 == 0) ? 0 : 3;
            step(1'b1, ch, (ch == 0) ? 100 : -100, i == 0, 1'b1, 4);
            checks++;
            if ({sample_out_valid, sample_out_ch, sample_out, sample_out_primed} !==
                {exp_valid, exp_ch, exp_out, exp_primed}) begin
                errors++;
                $display("FAIL interleave[%0d]: got ch=%0d out=%0d primed=%0b, want ch=%0d out=%0d primed=%0b",
                         i, sample_out_ch, $signed(sample_out), sample_out_primed,
                         exp_ch, $signed(exp_out), exp_primed);
            end
            if (i >= 38) begin
                checks++;
                if ($signed(sample_out) !== ((ch == 0) ? 16'sd100 : -16'sd100) || sample_out_primed !== 1'b1) begin
                    errors++;
                    $display("FAIL interleave_conv ch%0d: got out=%0d primed=%0b, want %0d primed=1",
                             ch, $signed(sample_out), sample_out_primed, (ch == 0) ? 100 : -100);
                end
            end
        end
    endtask

    task automatic test_winchange();
        for (int i = 0; i < 4; i++) step(1'b1, 0, 1000, i == 0, 1'b1, 2);
        checks++;
        if (sample_out !== 16'd1000 || sample_out_primed !== 1'b1) begin
            errors++;
            $display("FAIL winchange_fill: got out=%0d primed=%0b, want 1000 primed=1",
                     $signed(sample_out), sample_out_primed);
        end
        step(1'b1, 0, 800, 1'b0, 1'b1, 3);
        checks++;
        if (sample_out !== 16'd100 || sample_out_primed !== 1'b0) begin
            errors++;
            $display("FAIL winchange_flush: got out=%0d primed=%0b, want 100 primed=0",
                     $signed(sample_out), sample_out_primed);
        end
        for (int i = 0; i < 7; i++) step(1'b1, 0, 800, 1'b0, 1'b1, 3);
        checks++;
        if (sample_out !== 16'd800 || sample_out_primed !== 1'b1) begin
            errors++;
            $display("FAIL winchange_refill: got out=%0d primed=%0b, want 800 primed=1",
                     $signed(sample_out), sample_out_primed);
        end
    endtask

    task automatic test_fullscale();
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1, (i < 16) ? 32767 : -32768, i == 0, 1'b1, MAX_POW);
            checks++;
            if ({sample_out_valid, sample_out_ch, sample_out, sample_out_primed} !==
                {exp_valid, exp_ch, exp_out, exp_primed}) begin
                errors++;
                $display("FAIL fullscale[%0d]: got out=%0d primed=%0b, want out=%0d primed=%0b",
                         i, $signed(sample_out), sample_out_primed, $signed(exp_out), exp_primed);
            end
            if (i == 15 || i == 31) begin
                checks++;
                if (sample_out !== ((i == 15) ? 16'h7fff : 16'h8000)) begin
                    errors++;
                    $display("FAIL fullscale_end[%0d]: got out=%0d, want %0d",
                             i, $signed(sample_out), (i == 15) ? 32767 : -32768);
                end
            end
        end
    endtask

    task automatic test_invalid_channel();
        step(1'b1, 3, 55, 1'b0, 1'b1, 2);
        checks++;
        if (b_valid !== 1'b0 || sample_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL invalid_ch: got 3ch valid=%0b 4ch valid=%0b, want 0 and 1", b_valid, sample_out_valid);
        end
        step(1'b1, 2, 55, 1'b0, 1'b1, 2);
        checks++;
        if (b_valid !== 1'b1 || b_ch !== 2'd2) begin
            errors++;
            $display("FAIL valid_ch: got 3ch valid=%0b ch=%0d, want 1 ch=2", b_valid, b_ch);
        end
    endtask

    task automatic test_enable_toggle();
        int seq[9] = '{40, 40, 40, 40, 40, 10, 20, 30, 40};
        int eout[9] = '{10, 20, 30, 40, 40, 10, 20, 30, 25};
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1, seq[i], i == 0, !(i >= 5 && i <= 7), 2);
            checks++;
            if (sample_out !== 16'(eout[i]) || sample_out_ch !== 2'd1 || sample_out_valid !== 1'b1) begin
                errors++;
                $display("FAIL enable[%0d]: got out=%0d ch=%0d v=%0b, want out=%0d ch=1 v=1",
                         i, $signed(sample_out), sample_out_ch, sample_out_valid, eout[i]);
            end
        end
    endtask

    task automatic test_random();
        int wp = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) wp = $urandom_range(0, 7);
            step($urandom_range(0, 3) != 0, $urandom_range(0, NUM_CH - 1),
                 int'($urandom_range(0, 65535)) - 32768,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 7) != 0, wp);
            checks++;
            if ({sample_out_valid, sample_out_ch, sample_out, sample_out_primed} !==
                {exp_valid, exp_ch, exp_out, exp_primed}) begin
                errors++;
                $display("FAIL random[%0d]: got v=%0b ch=%0d out=%0d primed=%0b, want v=%0b ch=%0d out=%0d primed=%0b",
                         i, sample_out_valid, sample_out_ch, $signed(sample_out), sample_out_primed,
                         exp_valid, exp_ch, $signed(exp_out), exp_primed);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) step(1'b1, i % NUM_CH, 1234 + i, i == 0, 1'b1, 2);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({sample_out_valid, sample_out_ch, sample_out, sample_out_primed} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got v=%0b ch=%0d out=%0d primed=%0b, want all 0",
                     sample_out_valid, sample_out_ch, sample_out, sample_out_primed);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 2, 8, 1'b0, 1'b1, 2);
        checks++;
        if (sample_out !== 16'd2 || sample_out_primed !== 1'b0 || sample_out_ch !== 2'd2) begin
            errors++;
            $display("FAIL reset_resume: got out=%0d primed=%0b ch=%0d, want 2 primed=0 ch=2",
                     $signed(sample_out), sample_out_primed, sample_out_ch);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_negative();
        test_interleave();
        test_winchange();
        test_fullscale();
        test_invalid_channel();
        test_enable_toggle();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
